issue_select: RTL and testbench

//  Issue stage directly downstream of the reservation stations (rs). Each cycle, picks at most
//  one ready RS entry per functional-unit class, frees that entry, and latches its ISSUE_PACKET

---
 rtl/issue_select_pkg.sv | 28 ++
 rtl/issue_select_rr_picker.sv | 50 +++++
 rtl/issue_select.sv | 133 +++++++++++++
 tb/tb_issue_select.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
// ---------------------------------------------------------------------------
// issue_select_pkg
//   Shared types and constants for the issue-select stage: functional-unit
//   class encoding, the issue packet carried from the reservation stations
//   into the per-FU issue registers, and the number of FU classes.
//   No ports (package).
// ---------------------------------------------------------------------------
package issue_select_pkg;

    localparam int NUM_FU = 4;
    localparam int FU_W   = 3;

    // One code wider than the four classes need, so a corrupted or
    // not-yet-decoded class field can be represented and is never granted.
    typedef enum logic [FU_W-1:0] {
        FU_ALU   = 3'd0,
        FU_LOAD  = 3'd1,
        FU_STORE = 3'd2,
        FU_FP    = 3'd3
    } fu_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  dest_tag;
    } issue_packet_t;

endpackage

// File: rtl/issue_select_rr_picker.sv
// ---------------------------------------------------------------------------
// issue_select_rr_picker
//   Round-robin picker: selects the first asserted request at or after ptr,
//   wrapping modulo NUM_RS.
// Ports
//   req      in   NUM_RS   request vector (already masked to one class)
//   ptr      in   PTR_W    index with highest priority this cycle
//   gnt      out  NUM_RS   one-hot grant (all zero when no request)
//   gnt_idx  out  PTR_W    binary index of the granted entry
//   any      out  1        at least one request was granted
// ---------------------------------------------------------------------------
module issue_select_rr_picker #(
    parameter int NUM_RS = 5
) (
    input  logic [NUM_RS-1:0]         req,
    input  logic [$clog2(NUM_RS)-1:0] ptr,
    output logic [NUM_RS-1:0]         gnt,
    output logic [$clog2(NUM_RS)-1:0] gnt_idx,
    output logic                      any
);
    localparam int PTR_W = $clog2(NUM_RS);
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_RS);

    // One extra bit so ptr + offset never overflows before the explicit wrap.
    logic [PTR_W:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // no-request cycle would leave them unassigned and infer latches.
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        // Walk offsets from farthest to nearest so the nearest hit to ptr
        // is the last one written and therefore wins.
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (req[idx[PTR_W-1:0]]) begin
                gnt                   = '0;
                gnt[idx[PTR_W-1:0]]   = 1'b1;
                gnt_idx               = idx[PTR_W-1:0];
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// ---------------------------------------------------------------------------
// issue_select
//   Issue stage behind the reservation stations. Each cycle, per FU class,
//   picks at most one ready RS entry round-robin, tells the RS to free it,
//   and latches its packet into that class's issue register feeding EX.
// Ports
//   clock      in   1                    system clock
//   reset      in   1                    synchronous, active-high reset
//   squash     in   1                    mispredict flush: blocks grants, kills issue regs
//   rs_busy    in   NUM_RS               entry holds an instruction
//   rs_ready   in   NUM_RS               entry's source operands are resolved
//   rs_fu      in   NUM_RS x fu_type_e   FU class of each entry
//   rs_packet  in   NUM_RS x packet      entry contents
//   fu_ready   in   NUM_FU               FU consumes its issue register this cycle
//   rs_clear   out  NUM_RS               granted entries (at most one per class)
//   ex_valid   out  NUM_FU               issue register holds a valid instruction
//   ex_packet  out  NUM_FU x packet      issue register contents
// ---------------------------------------------------------------------------
module issue_select
    import issue_select_pkg::*;
#(
    parameter int NUM_RS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic [NUM_RS-1:0]   rs_busy,
    input  logic [NUM_RS-1:0]   rs_ready,
    input  fu_type_e            rs_fu     [NUM_RS],
    input  issue_packet_t       rs_packet [NUM_RS],
    input  logic [NUM_FU-1:0]   fu_ready,
    output logic [NUM_RS-1:0]   rs_clear,
    output logic [NUM_FU-1:0]   ex_valid,
    output issue_packet_t       ex_packet [NUM_FU]
);
    localparam int PTR_W = $clog2(NUM_RS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_RS - 1);

    logic [NUM_RS-1:0]  eligible;
    logic [NUM_FU-1:0]  slot_free;
    logic [NUM_FU-1:0]  grant_any;
    logic [NUM_RS-1:0]  req      [NUM_FU];
    logic [NUM_RS-1:0]  gnt      [NUM_FU];
    logic [PTR_W-1:0]   gnt_idx  [NUM_FU];

    logic [NUM_FU-1:0]  ex_valid_q,  ex_valid_d;
    issue_packet_t      ex_packet_q [NUM_FU];
    issue_packet_t      ex_packet_d [NUM_FU];
    logic [PTR_W-1:0]   rr_ptr_q    [NUM_FU];
    logic [PTR_W-1:0]   rr_ptr_d    [NUM_FU];

    assign eligible  = rs_busy & rs_ready;
    // A register that is being drained this cycle can be refilled in the same cycle.
    assign slot_free = ~ex_valid_q | fu_ready;

    // Class masking. Out-of-range class codes match no FU and are never granted;
    // squash and reset suppress every grant so the RS keeps its entries.
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            req[f] = '0;
            for (int i = 0; i < NUM_RS; i++) begin
                req[f][i] = eligible[i] && (rs_fu[i] == FU_W'(f)) &&
                            slot_free[f] && !squash && !reset;
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        issue_select_rr_picker #(
            .NUM_RS (NUM_RS)
        ) u_picker (
            .req     (req[f]),
            .ptr     (rr_ptr_q[f]),
            .gnt     (gnt[f]),
            .gnt_idx (gnt_idx[f]),
            .any     (grant_any[f])
        );
    end

    always_comb begin
        rs_clear = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            rs_clear = rs_clear | gnt[f];
        end
    end

    // Priority per class: squash kills, else a grant refills, else a consumed
    // register empties, else hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        for (int f = 0; f < NUM_FU; f++) begin
            ex_packet_d[f] = ex_packet_q[f];
            rr_ptr_d[f]    = rr_ptr_q[f];
            if (squash) begin
                ex_valid_d[f] = 1'b0;
            end else if (grant_any[f]) begin
                ex_valid_d[f]  = 1'b1;
                ex_packet_d[f] = rs_packet[gnt_idx[f]];
                rr_ptr_d[f]    = (gnt_idx[f] == LAST_IDX) ? '0 : gnt_idx[f] + PTR_W'(1);
            end else if (fu_ready[f]) begin
                ex_valid_d[f] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                // NOTE: the packet registers are cleared too, so nothing seen
                // on ex_packet after reset depends on pre-reset contents.
                ex_packet_q[f] <= '0;
                rr_ptr_q[f]    <= '0;
            end
        end else begin
            ex_valid_q <= ex_valid_d;
            for (int f = 0; f < NUM_FU; f++) begin
                ex_packet_q[f] <= ex_packet_d[f];
                rr_ptr_q[f]    <= rr_ptr_d[f];
            end
        end
    end

    assign ex_valid = ex_valid_q;
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            ex_packet[f] = ex_packet_q[f];
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// ---------------------------------------------------------------------------
// tb_issue_select
//   Self-checking bench for issue_select. Expected issue packets are queued
//   when a grant is expected and popped after the following clock edge.
// ---------------------------------------------------------------------------
module tb_issue_select;
    import issue_select_pkg::*;

    localparam int NUM_RS = 5;

    logic                clock = 1'b0;
    logic                reset;
    logic                squash;
    logic [NUM_RS-1:0]   rs_busy;
    logic [NUM_RS-1:0]   rs_ready;
    fu_type_e            rs_fu     [NUM_RS];
    issue_packet_t       rs_packet [NUM_RS];
    logic [NUM_FU-1:0]   fu_ready;
    logic [NUM_RS-1:0]   rs_clear;
    logic [NUM_FU-1:0]   ex_valid;
    issue_packet_t       ex_packet [NUM_FU];

    typedef struct {
        int            fu;
        issue_packet_t pkt;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    issue_select #(.NUM_RS(NUM_RS)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .rs_busy   (rs_busy),
        .rs_ready  (rs_ready),
        .rs_fu     (rs_fu),
        .rs_packet (rs_packet),
        .fu_ready  (fu_ready),
        .rs_clear  (rs_clear),
        .ex_valid  (ex_valid),
        .ex_packet (ex_packet)
    );

    always #5 clock = ~clock;

    function automatic issue_packet_t mk_pkt(int i, int gen);
        issue_packet_t p;
        p.pc       = 32'h0000_1000 + 32'(i * 4);
        p.inst     = 32'hC0DE_0000 + 32'(gen * 16 + i);
        p.dest_tag = 6'(i + 8 * gen);
        return p;
    endfunction

    task automatic idle_inputs();
        squash   = 1'b0;
        rs_busy  = '0;
        rs_ready = '0;
        fu_ready = '0;
        for (int i = 0; i < NUM_RS; i++) rs_packet[i] = mk_pkt(i, 0);
    endtask

    // Leaves time 1 unit after a rising edge: registered outputs are stable
    // and inputs may be changed for the next cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset held 3 cycles with everything eligible, then all four classes grant at once.
    task automatic test_reset();
        reset    = 1'b1;
        rs_busy  = '1;
        rs_ready = '1;
        fu_ready = '1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (rs_clear !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_rs_clear[%0d]: got %b expected 00000", c, rs_clear);
            end
            tick();
            n_cmp++;
            if (ex_valid !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ex_valid[%0d]: got %b expected 0000", c, ex_valid);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b01111) begin
            n_bad++;
            $display("FAIL first_grant_rs_clear: got %b expected 01111", rs_clear);
        end
        sb_q.push_back('{fu: 0, pkt: mk_pkt(0, 0)});
        sb_q.push_back('{fu: 1, pkt: mk_pkt(1, 0)});
        sb_q.push_back('{fu: 2, pkt: mk_pkt(2, 0)});
        sb_q.push_back('{fu: 3, pkt: mk_pkt(3, 0)});
        tick();
        while (sb_q.size() != 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (ex_valid[e.fu] !== 1'b1 || ex_packet[e.fu] !== e.pkt) begin
                n_bad++;
                $display("FAIL first_grant_pkt fu%0d: got v=%b %h expected v=1 %h",
                         e.fu, ex_valid[e.fu], ex_packet[e.fu], e.pkt);
            end
        end
        // Nothing eligible while every FU consumes: all registers drain.
        rs_busy = '0;
        tick();
        n_cmp++;
        if (ex_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL drain_no_refill: got %b expected 0000", ex_valid);
        end
    endtask

    // FP entries 3 and 4 stay eligible for three cycles: grants alternate 3,4,3.
    task automatic test_fp_round_robin();
        int order [3] = '{3, 4, 3};
        do_reset();
        rs_busy[3]  = 1'b1; rs_ready[3] = 1'b1;
        rs_busy[4]  = 1'b1; rs_ready[4] = 1'b1;
        fu_ready[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            logic [NUM_RS-1:0] exp_clr;
            exp_clr = '0;
            exp_clr[order[c]] = 1'b1;
            #1;
            n_cmp++;
            if (rs_clear !== exp_clr) begin
                n_bad++;
                $display("FAIL fp_rr_clear[%0d]: got %b expected %b", c, rs_clear, exp_clr);
            end
            sb_q.push_back('{fu: 3, pkt: mk_pkt(order[c], 0)});
            tick();
            while (sb_q.size() != 0) begin
                sb_entry_t e;
                e = sb_q.pop_front();
                n_cmp++;
                if (ex_valid[e.fu] !== 1'b1 || ex_packet[e.fu] !== e.pkt) begin
                    n_bad++;
                    $display("FAIL fp_rr_pkt[%0d]: got v=%b %h expected v=1 %h",
                             c, ex_valid[e.fu], ex_packet[e.fu], e.pkt);
                end
            end
        end
    endtask

    // ALU register held for 4 cycles while entry 0 waits; released on fu_ready.
    task automatic test_backpressure();
        do_reset();
        rs_busy[0] = 1'b1; rs_ready[0] = 1'b1; fu_ready[0] = 1'b1;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00001) begin
            n_bad++;
            $display("FAIL bp_first_clear: got %b expected 00001", rs_clear);
        end
        tick();
        fu_ready[0]  = 1'b0;
        rs_packet[0] = mk_pkt(0, 1);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (rs_clear !== 5'b00000) begin
                n_bad++;
                $display("FAIL bp_hold_clear[%0d]: got %b expected 00000", c, rs_clear);
            end
            tick();
            n_cmp++;
            if (ex_valid[0] !== 1'b1 || ex_packet[0] !== mk_pkt(0, 0)) begin
                n_bad++;
                $display("FAIL bp_hold_pkt[%0d]: got v=%b %h expected v=1 %h",
                         c, ex_valid[0], ex_packet[0], mk_pkt(0, 0));
            end
        end
        fu_ready[0] = 1'b1;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00001) begin
            n_bad++;
            $display("FAIL bp_release_clear: got %b expected 00001", rs_clear);
        end
        sb_q.push_back('{fu: 0, pkt: mk_pkt(0, 1)});
        tick();
        while (sb_q.size() != 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (ex_valid[e.fu] !== 1'b1 || ex_packet[e.fu] !== e.pkt) begin
                n_bad++;
                $display("FAIL bp_release_pkt: got v=%b %h expected v=1 %h",
                         ex_valid[e.fu], ex_packet[e.fu], e.pkt);
            end
        end
    endtask

    // Squash beats a pending Store grant and a held Load register.
    task automatic test_squash();
        do_reset();
        rs_busy[1] = 1'b1; rs_ready[1] = 1'b1; fu_ready[1] = 1'b1;
        tick();
        rs_busy[1] = 1'b0; rs_ready[1] = 1'b0; fu_ready[1] = 1'b0;
        rs_busy[2] = 1'b1; rs_ready[2] = 1'b1; fu_ready[2] = 1'b1;
        squash = 1'b1;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00000 || ex_valid !== 4'b0010) begin
            n_bad++;
            $display("FAIL squash_clear: got clr=%b v=%b expected clr=00000 v=0010",
                     rs_clear, ex_valid);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL squash_kill: got %b expected 0000", ex_valid);
        end
        squash = 1'b0;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00100) begin
            n_bad++;
            $display("FAIL post_squash_clear: got %b expected 00100", rs_clear);
        end
        sb_q.push_back('{fu: 2, pkt: mk_pkt(2, 0)});
        tick();
        n_cmp++;
        if (ex_valid !== 4'b0100) begin
            n_bad++;
            $display("FAIL post_squash_valid: got %b expected 0100", ex_valid);
        end
        while (sb_q.size() != 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (ex_packet[e.fu] !== e.pkt) begin
                n_bad++;
                $display("FAIL post_squash_pkt: got %h expected %h", ex_packet[e.fu], e.pkt);
            end
        end
    endtask

    // Not-busy and out-of-range-class entries never grant; idle fu_ready does nothing.
    task automatic test_ineligible();
        do_reset();
        rs_ready[0] = 1'b1;
        fu_ready    = '1;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00000) begin
            n_bad++;
            $display("FAIL not_busy_clear: got %b expected 00000", rs_clear);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL not_busy_valid: got %b expected 0000", ex_valid);
        end
        rs_busy[0] = 1'b1;
        rs_fu[0]   = fu_type_e'(3'd5);
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00000) begin
            n_bad++;
            $display("FAIL bad_class_clear: got %b expected 00000", rs_clear);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL bad_class_valid: got %b expected 0000", ex_valid);
        end
        rs_fu[0] = FU_ALU;
    endtask

    // Reset during an FP hold clears the register and the round-robin pointer.
    task automatic test_reset_mid_hold();
        do_reset();
        rs_busy[3] = 1'b1; rs_ready[3] = 1'b1; fu_ready[3] = 1'b1;
        tick();
        rs_busy[3] = 1'b0; rs_ready[3] = 1'b0; fu_ready[3] = 1'b0;
        tick();
        n_cmp++;
        if (ex_valid[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL fp_hold_valid: got %b expected 1", ex_valid[3]);
        end
        reset = 1'b1;
        rs_busy[3] = 1'b1; rs_ready[3] = 1'b1;
        rs_busy[4] = 1'b1; rs_ready[4] = 1'b1;
        #1;
        n_cmp++;
        if (rs_clear !== 5'b00000) begin
            n_bad++;
            $display("FAIL mid_hold_reset_clear: got %b expected 00000", rs_clear);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 4'b0000 || ex_packet[3] !== '0) begin
            n_bad++;
            $display("FAIL mid_hold_reset_regs: got v=%b pkt=%h expected v=0000 pkt=0",
                     ex_valid, ex_packet[3]);
        end
        reset = 1'b0;
        fu_ready[3] = 1'b1;
        #1;
        // Pointer was 4 before reset; a cleared pointer must pick entry 3.
        n_cmp++;
        if (rs_clear !== 5'b01000) begin
            n_bad++;
            $display("FAIL ptr_after_reset: got %b expected 01000", rs_clear);
        end
        sb_q.push_back('{fu: 3, pkt: mk_pkt(3, 0)});
        tick();
        while (sb_q.size() != 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (ex_valid[e.fu] !== 1'b1 || ex_packet[e.fu] !== e.pkt) begin
                n_bad++;
                $display("FAIL ptr_after_reset_pkt: got v=%b %h expected v=1 %h",
                         ex_valid[e.fu], ex_packet[e.fu], e.pkt);
            end
        end
    endtask

    initial begin
        rs_fu[0] = FU_ALU;
        rs_fu[1] = FU_LOAD;
        rs_fu[2] = FU_STORE;
        rs_fu[3] = FU_FP;
        rs_fu[4] = FU_FP;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fp_round_robin();
        test_backpressure();
        test_squash();
        test_ineligible();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
